// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_loader.
// The master side is the loader; the slave side is the stream source, the memory and the CPU control.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, we, wa, wd, cpu_hold, done, err
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, we, wa, wd, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses an A5/count/payload/XOR-checksum frame, writes 32-bit words into
// instruction memory, and keeps the CPU held until a frame with a good checksum lands.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus
);

  localparam logic [7:0] HDR     = 8'hA5;
  localparam logic [7:0] DEPTH_N = 8'(DEPTH);

  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic [7:0]          n_q, n_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [7:0]          acc_q, acc_d;
  logic [23:0]         word_q, word_d;
  logic [31:0]         wd_q, wd_d;
  logic [31:0]         wa_q, wa_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                hold_q, hold_d;
  logic                rx_ready;
  logic                accept;
  logic                last_word;

  // The only back-pressure cycle is the write strobe, giving 4 bytes per 5 cycles.
  assign rx_ready  = ~we_q;
  assign accept    = bus.rx_valid && rx_ready;
  assign last_word = (8'(idx_q) == (n_q - 8'd1));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    acc_d   = acc_q;
    word_d  = word_q;
    wd_d    = wd_q;
    wa_d    = wa_q;
    we_d    = 1'b0;

    if (we_q) idx_d = idx_q + 1'b1;

    if (accept) begin
      case (state_q)
        IDLE: if (bus.rx_data == HDR) state_d = COUNT;
        COUNT: begin
          if (bus.rx_data == 8'd0 || bus.rx_data > DEPTH_N) begin
            state_d = ERR;
          end else begin
            n_d     = bus.rx_data;
            idx_d   = '0;
            bcnt_d  = 2'd0;
            acc_d   = 8'd0;
            state_d = DATA;
          end
        end
        DATA: begin
          acc_d  = acc_q ^ bus.rx_data;
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: word_d[7:0]   = bus.rx_data;
            2'd1: word_d[15:8]  = bus.rx_data;
            2'd2: word_d[23:16] = bus.rx_data;
            default: begin
              wd_d = {bus.rx_data, word_q};
              wa_d = 32'(idx_q) << 2;
              we_d = 1'b1;
              if (last_word) state_d = CHECK;
            end
          endcase
        end
        CHECK: state_d = (bus.rx_data == acc_q) ? DONE : ERR;
        DONE, ERR: if (bus.rx_data == HDR) state_d = COUNT;
        default: state_d = IDLE;
      endcase
    end

    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
    hold_d = (state_d != DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= 8'd0;
      idx_q   <= '0;
      bcnt_q  <= 2'd0;
      acc_q   <= 8'd0;
      word_q  <= 24'd0;
      wd_q    <= 32'd0;
      wa_q    <= 32'd0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      wd_q    <= wd_d;
      wa_q    <= wa_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.we       = we_q;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign bus.cpu_hold = hold_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes go into a scoreboard queue when a word
// is streamed and are popped by a monitor whenever the write strobe fires.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  acc;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every strobe must match the oldest expected write and stall the stream.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      check("rx_ready_in_we", 32'(bus.rx_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(bus.we), 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wa", bus.wa, e[63:32]);
        check("wd", bus.wd, e[31:0]);
      end
    end
  end

  // Entered and left at a falling edge; the byte is taken on the rising edge where ready was high.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int k = 0; k < 8 && !got; k++) begin
      if (bus.rx_ready === 1'b1) got = 1'b1;
      @(negedge clk);
    end
    if (!got) check("byte_timeout", 32'(got), 32'd1);
  endtask

  task automatic send_word(input int k, input logic [31:0] w);
    exp_q.push_back({32'(k * 4), w});
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      acc = acc ^ w[8*i +: 8];
    end
    check("we_latency", 32'(bus.we), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"}, 32'(bus.done), 32'(d));
    check({tag, "_err"},  32'(bus.err),  32'(e));
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'(h));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.rx_ready), 32'd1);
    check({tag, "_we"},    32'(bus.we), 32'd0);
    check({tag, "_wa"},    bus.wa, 32'd0);
    check({tag, "_wd"},    bus.wd, 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    idle(1);

    // Garbage in IDLE is dropped.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    idle(2);
    check_status("garbage", 1'b0, 1'b0, 1'b1);

    // Single word, back-to-back.
    send_byte(8'hA5); send_byte(8'h01); acc = 8'h00;
    send_word(0, 32'h7FF00F13);
    check("sum1", 32'(acc), 32'h93);
    send_byte(acc);
    check_status("single", 1'b1, 1'b0, 1'b0);
    idle(2);

    // Two words with rx_valid held high across the write stall.
    send_byte(8'hA5);
    check_status("reload_hdr", 1'b0, 1'b0, 1'b1);
    send_byte(8'h02); acc = 8'h00;
    send_word(0, 32'h7FF00F13);
    send_word(1, 32'h00D00E13);
    check("sum2", 32'(acc), 32'h5E);
    send_byte(acc);
    check_status("two", 1'b1, 1'b0, 1'b0);
    idle(2);

    // Bad counts: zero, then one above DEPTH.
    send_byte(8'hA5); send_byte(8'h00);
    check_status("cnt0", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5);
    check_status("err_hdr", 1'b0, 1'b0, 1'b1);
    send_byte(8'h41);
    check_status("cnt65", 1'b0, 1'b1, 1'b1);
    idle(2);

    // Checksum mismatch: write still happens, frame rejected; next good frame recovers.
    send_byte(8'hA5); send_byte(8'h01); acc = 8'h00;
    send_word(0, 32'h7FF00F13);
    send_byte(8'h00);
    check_status("badsum", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5); send_byte(8'h01); acc = 8'h00;
    send_word(0, 32'hDEADBEEF);
    send_byte(acc);
    check_status("recover", 1'b1, 1'b0, 1'b0);

    // Garbage in DONE is ignored; a new header re-holds the CPU until the frame completes.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    check_status("done_garbage", 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5);
    check_status("second_hdr", 1'b0, 1'b0, 1'b1);
    send_byte(8'h01); acc = 8'h00;
    send_word(0, 32'h01234567);
    check_status("mid_frame", 1'b0, 1'b0, 1'b1);
    send_byte(acc);
    check_status("second_done", 1'b1, 1'b0, 1'b0);

    // Full-depth image: 64 words up to wa=0xFC.
    send_byte(8'hA5); send_byte(8'h40); acc = 8'h00;
    for (int k = 0; k < 64; k++) send_word(k, $urandom);
    send_byte(acc);
    check_status("full", 1'b1, 1'b0, 1'b0);
    check("full_last_wa", bus.wa, 32'h000000FC);

    // Reset mid-word: partial word discarded, outputs return to reset values.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h13); send_byte(8'h0F);
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid1");
    @(negedge clk);
    check_reset_outputs("rst_mid2");
    reset = 1'b0;
    idle(2);
    check_reset_outputs("rst_after");
    send_byte(8'hA5); send_byte(8'h01); acc = 8'h00;
    send_word(0, 32'hCAFE0001);
    send_byte(acc);
    check_status("post_rst", 1'b1, 1'b0, 1'b0);
    idle(3);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the CPU's writable instruction memory from a byte stream (UART receiver or debug bridge). It parses a framed little-endian image, issues one 32-bit word write per four bytes on the memory's write port, verifies an XOR checksum, and holds the pipeline in reset until a valid image is in place. It sits between the byte-stream source and the instruction-memory write port, beside the fetch stage that reads the same memory.

## Interface
- DEPTH, 64: instruction-memory size in 32-bit words; legal word count is 1..DEPTH (DEPTH ≤ 255).
- ADDR_W, 6: word-index width, equal to clog2(DEPTH).

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock; forces all outputs to reset values immediately
- rx_valid  in  1  rx_data holds a byte
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts a byte this cycle; reset 1
- we  out  1  one-cycle instruction-memory write strobe; reset 0
- wa  out  32  byte address, word aligned; wa[1:0]=0, wa[31:ADDR_W+2]=0; reset 0
- wd  out  32  write data; reset 0
- cpu_hold  out  1  hold CPU in reset; reset 1
- done  out  1  valid image loaded; reset 0
- err  out  1  last frame rejected; reset 0

## Operation
- Frame: header 0xA5, count byte N (words), N×4 payload bytes (little-endian, least significant byte first), checksum byte = XOR of all payload bytes.
- Byte accepted only on an edge where rx_valid && rx_ready.
- States: IDLE, COUNT, DATA, CHECK, DONE, ERR.
- IDLE: non-0xA5 bytes are discarded silently. 0xA5 -> COUNT.
- COUNT: N==0 or N>DEPTH -> ERR. Otherwise latch N, clear word index, byte counter and checksum accumulator, then -> DATA.
- DATA: shift each byte into byte lane [8·b+7:8·b], b = byte counter 0..3, and XOR it into the accumulator. On the 4th byte, register wd = assembled word and wa = index<<2. Pulse we the following cycle, then increment the index. After word N-1 is written -> CHECK.
- CHECK: byte == accumulator -> DONE, otherwise -> ERR.
- DONE: done=1, cpu_hold=0. A 0xA5 header -> COUNT, with done=0 and cpu_hold=1 from the next cycle. All other bytes are ignored.
- ERR: err=1, cpu_hold=1. A 0xA5 header -> COUNT and clears err. All other bytes are ignored.
- cpu_hold=1 in every state except DONE.
- Writes are not rolled back on checksum failure; cpu_hold stays high, so the CPU never runs a bad image.
- Index counter is ADDR_W bits. The count check guarantees it never wraps within a frame.
- A 0xA5 byte inside DATA or CHECK is payload or checksum, never a header.

## Timing
- rx_ready is 0 exactly in the cycle we=1; it is 1 in all other cycles. Sustained throughput is 4 bytes per 5 cycles.
- Write latency: 4th byte of word k accepted at edge t -> we=1 with wa=4k, wd=word during cycle t..t+1. we is high for exactly one cycle.
- wa and wd hold their last values when we=0.
- done, err and cpu_hold are registered. They change in the cycle after the checksum byte is accepted (or after the count byte, for count errors).
- Reset at any point (mid-word or mid-frame) aborts the frame. The partial word is discarded and not written, and the state returns to IDLE with reset output values. Words already written stay in memory.
- rx_valid with rx_ready=0: the byte is not consumed. The source must hold it.

## Test plan
- Single word: stream A5 01 13 0F F0 7F 93 back-to-back. Required: one we pulse with wa=0x0, wd=0x7FF00F13. Then done=1, cpu_hold=0, err=0.
- Two words with stall: stream A5 02 13 0F F0 7F 13 0E D0 00 5E with rx_valid held high throughout. Required: we at wa=0x0 (0x7FF00F13) and wa=0x4 (0x00D00E13), with rx_ready=0 in each we cycle and no byte lost. Then done=1.
- Bad count: send A5 00 -> err=1, no we. Then A5 41 (65 > DEPTH) -> err=1, no we. cpu_hold stays 1 throughout.
- Checksum mismatch: stream A5 01 13 0F F0 7F 00. Required: we pulse occurs, then err=1, done=0, cpu_hold=1. A following good frame clears err and sets done.
- Garbage and reload: send 00 FF 3C, then a good frame -> done=1. Then send a second frame header A5 -> cpu_hold=1, done=0 until that frame completes.
- Reset mid-frame: send A5 01 13 0F, assert reset for 2 cycles. Required: outputs at reset values with no we. A following good frame loads correctly at wa=0.
